// File: rtl/spi_reg_burst.sv
// SPI target giving a host burst read/write access to a register bank.
// Parametrised in word width, address width, SPI mode and address auto-increment.
module spi_reg_burst #(
    parameter int ADDR_W   = 7,
    parameter int REG_W    = 8,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic              busy,
    input  logic [7:0]        status
);

    localparam int                CNT_W     = $clog2(REG_W);
    localparam logic              POL       = 1'(CPOL);
    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(REG_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(AUTO_INC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [1:0]        sclk_sync;
    logic [1:0]        cs_sync;
    logic [1:0]        mosi_sync;
    logic              sclk_prev;
    logic              cs_prev;

    logic              sclk_n;
    logic              lead_edge;
    logic              trail_edge;
    logic              sample_edge;
    logic              change_edge;
    logic              sof;
    logic              eof;
    logic              start;

    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_last;
    logic [REG_W-1:0]  rx_sr;
    logic [REG_W-1:0]  tx_buf;
    logic              tx_seen;
    logic              unit_done;
    logic              wr_q;
    logic              ld_q;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else if (ena) begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_prev <= sclk_n;
            cs_prev   <= cs_sync[1];
        end
    end

    // Normalise polarity so the leading edge is always a rise of sclk_n.
    assign sclk_n      = sclk_sync[1] ^ POL;
    assign lead_edge   = sclk_n & ~sclk_prev & ~cs_sync[1];
    assign trail_edge  = ~sclk_n & sclk_prev & ~cs_sync[1];
    assign sample_edge = ((CPHA != 0) ? trail_edge : lead_edge) & (state_q != IDLE);
    assign change_edge = ((CPHA != 0) ? lead_edge : trail_edge) & (state_q != IDLE);
    assign sof         = cs_prev & ~cs_sync[1];
    assign eof         = ~cs_prev & cs_sync[1];
    assign start       = sof & (state_q == IDLE);

    assign bit_last    = (state_q == CMD) ? CMD_LAST : WORD_LAST;
    assign cmd_rw      = rx_sr[7];
    assign cmd_addr    = rx_sr[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // NOTE: next-state logic starts from a default so no path leaves
    // state_d unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = CMD;
            CMD:     if (unit_done) state_d = cmd_rw ? WR_DATA : RD_DATA;
            default: ;
        endcase
        if (eof) state_d = IDLE;
    end

    always_comb begin
        busy     = (state_q != IDLE);
        reg_wr   = wr_q & ena;
        reg_rd   = ld_q & ena;
        spi_miso = tx_buf[REG_W-1];
    end

    // unit_done marks the clk after the last bit of a command byte or data word.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_sr     <= '0;
            bit_cnt   <= '0;
            unit_done <= 1'b0;
        end else if (ena) begin
            if (sample_edge) rx_sr <= {rx_sr[REG_W-2:0], mosi_sync[1]};
            if (start) begin
                bit_cnt <= '0;
            end else if (sample_edge) begin
                bit_cnt <= (bit_cnt == bit_last) ? '0 : bit_cnt + CNT_ONE;
            end
            unit_done <= sample_edge && (bit_cnt == bit_last);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            reg_addr   <= '0;
            reg_data_o <= '0;
            wr_q       <= 1'b0;
            ld_q       <= 1'b0;
        end else if (ena) begin
            wr_q <= unit_done && (state_q == WR_DATA);
            ld_q <= unit_done && !eof
                    && (((state_q == CMD) && !cmd_rw) || (state_q == RD_DATA));
            if (unit_done && (state_q == WR_DATA)) reg_data_o <= rx_sr;
            // Address moves only after the write strobe so reg_addr is stable during it.
            if (unit_done && (state_q == CMD)) begin
                reg_addr <= cmd_addr;
            end else if (wr_q || (unit_done && (state_q == RD_DATA))) begin
                reg_addr <= reg_addr + ADDR_STEP;
            end
        end
    end

    // A fresh load keeps its MSB on the wire until the host has sampled it once.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tx_buf  <= '0;
            tx_seen <= 1'b0;
        end else if (ena) begin
            if (start) begin
                tx_buf  <= REG_W'(status) << (REG_W - 8);
                tx_seen <= 1'b0;
            end else if (ld_q) begin
                tx_buf  <= reg_data_i;
                tx_seen <= 1'b0;
            end else begin
                if (change_edge && tx_seen) tx_buf <= tx_buf << 1;
                if (sample_edge) tx_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_burst.sv
// Bench for spi_reg_burst: three instances in different modes, driven by a bit-level
// SPI host; frame results compared with a register-bank model built from the frame rules.
module tb_spi_reg_burst;

    localparam int NI = 3;
    localparam int H  = 6;
    localparam int W_A   [NI] = '{8, 16, 32};
    localparam int AW_A  [NI] = '{7, 7, 5};
    localparam int INC_A [NI] = '{1, 1, 0};
    localparam bit POL_A [NI] = '{1'b0, 1'b1, 1'b0};
    localparam bit PHA_A [NI] = '{1'b0, 1'b1, 1'b1};

    logic          clk  = 1'b0;
    logic          rstb = 1'b0;
    logic          ena  = 1'b1;
    logic [NI-1:0] sclk = 3'b010;
    logic [NI-1:0] csn  = 3'b111;
    logic [NI-1:0] mosi = 3'b000;
    logic [NI-1:0] miso;
    logic [NI-1:0] wr;
    logic [NI-1:0] rd;
    logic [NI-1:0] busy;
    logic [7:0]    status [NI];

    logic [6:0]  ra0, ra1;
    logic [4:0]  ra2;
    logic [7:0]  rdi0, rdo0;
    logic [15:0] rdi1, rdo1;
    logic [31:0] rdi2, rdo2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register bank contents seen by each instance; 0x1111 per address on instance 1.
    function automatic logic [31:0] bank(int i, logic [31:0] a);
        case (i)
            0:       return (a * 32'd37 + 32'd11) & 32'hFF;
            1:       return (a * 32'h1111) & 32'hFFFF;
            default: return (a * 32'h01020304) ^ 32'hDEAD0000;
        endcase
    endfunction

    assign rdi0 = 8'(bank(0, 32'(ra0)));
    assign rdi1 = 16'(bank(1, 32'(ra1)));
    assign rdi2 = bank(2, 32'(ra2));

    spi_reg_burst #(.ADDR_W(7), .REG_W(8), .CPOL(0), .CPHA(0), .AUTO_INC(1)) u_m0 (
        .clk(clk), .rstb(rstb), .ena(ena), .spi_clk(sclk[0]), .spi_cs_n(csn[0]),
        .spi_mosi(mosi[0]), .spi_miso(miso[0]), .reg_addr(ra0), .reg_data_i(rdi0),
        .reg_data_o(rdo0), .reg_wr(wr[0]), .reg_rd(rd[0]), .busy(busy[0]), .status(status[0]));

    spi_reg_burst #(.ADDR_W(7), .REG_W(16), .CPOL(1), .CPHA(1), .AUTO_INC(1)) u_m3 (
        .clk(clk), .rstb(rstb), .ena(ena), .spi_clk(sclk[1]), .spi_cs_n(csn[1]),
        .spi_mosi(mosi[1]), .spi_miso(miso[1]), .reg_addr(ra1), .reg_data_i(rdi1),
        .reg_data_o(rdo1), .reg_wr(wr[1]), .reg_rd(rd[1]), .busy(busy[1]), .status(status[1]));

    spi_reg_burst #(.ADDR_W(5), .REG_W(32), .CPOL(0), .CPHA(1), .AUTO_INC(0)) u_m1 (
        .clk(clk), .rstb(rstb), .ena(ena), .spi_clk(sclk[2]), .spi_cs_n(csn[2]),
        .spi_mosi(mosi[2]), .spi_miso(miso[2]), .reg_addr(ra2), .reg_data_i(rdi2),
        .reg_data_o(rdo2), .reg_wr(wr[2]), .reg_rd(rd[2]), .busy(busy[2]), .status(status[2]));

    function automatic logic [31:0] addr_of(int i);
        case (i)
            0:       return 32'(ra0);
            1:       return 32'(ra1);
            default: return 32'(ra2);
        endcase
    endfunction

    function automatic logic [31:0] rdo_of(int i);
        case (i)
            0:       return 32'(rdo0);
            1:       return 32'(rdo1);
            default: return rdo2;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         inst;
        logic [6:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t  wlog [$];
    int   rd_cnt [NI];
    logic rxb [$];
    int   pause_at = -1;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            if (wr[i]) wlog.push_back('{i, 7'(addr_of(i)), rdo_of(i)});
            if (rd[i]) rd_cnt[i]++;
        end
    end

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(int i, logic b);
        logic m;
        if (!PHA_A[i]) begin
            mosi[i] = b;
            wait_clk(H);
            m = miso[i];
            sclk[i] = ~POL_A[i];
            wait_clk(H);
            sclk[i] = POL_A[i];
        end else begin
            wait_clk(H);
            sclk[i] = ~POL_A[i];
            mosi[i] = b;
            wait_clk(H);
            m = miso[i];
            sclk[i] = POL_A[i];
        end
        rxb.push_back(m);
    endtask

    // Drives cmd + n words, cut short after lim bits when lim >= 0.
    task automatic drive_frame(int i, logic [7:0] cmd, int n, logic [3:0][31:0] d, int lim);
        logic bq [$];
        for (int b = 7; b >= 0; b--) bq.push_back(cmd[b]);
        for (int k = 0; k < n; k++)
            for (int b = W_A[i] - 1; b >= 0; b--) bq.push_back(d[k][b]);
        if (lim < 0) lim = bq.size();
        rxb.delete();
        wlog.delete();
        rd_cnt = '{default: 0};
        status[i] = 8'($urandom);
        csn[i] = 1'b0;
        wait_clk(H);
        for (int j = 0; j < lim; j++) begin
            if (j == pause_at) begin
                ena = 1'b0;
                wait_clk(25);
                ena = 1'b1;
            end
            bit_xfer(i, bq[j]);
        end
        wait_clk(H);
        csn[i] = 1'b1;
        wait_clk(3 * H);
    endtask

    task automatic do_frame(string tag, int i, logic [7:0] cmd, int n, logic [3:0][31:0] d,
                            logic [3:0][6:0] ea, logic [6:0] efin);
        logic [7:0]  s;
        logic [31:0] w;
        logic [31:0] msk;
        drive_frame(i, cmd, n, d, -1);
        msk = (W_A[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << W_A[i]) - 32'd1);
        for (int b = 0; b < 8; b++) s[7-b] = rxb[b];
        check({tag, ".status"}, 32'(s), 32'(status[i]));
        if (cmd[7]) begin
            check({tag, ".wr_cnt"}, 32'(wlog.size()), 32'(n));
            for (int k = 0; k < n && k < wlog.size(); k++) begin
                check($sformatf("%s.wr%0d_inst", tag, k), 32'(wlog[k].inst), 32'(i));
                check($sformatf("%s.wr%0d_addr", tag, k), 32'(wlog[k].a), 32'(ea[k]));
                check($sformatf("%s.wr%0d_data", tag, k), wlog[k].d, d[k] & msk);
            end
            check({tag, ".rd_cnt"}, 32'(rd_cnt[i]), 32'd0);
        end else begin
            check({tag, ".wr_cnt"}, 32'(wlog.size()), 32'd0);
            // One load after the command and one after each word, the last being a prefetch.
            check({tag, ".rd_cnt"}, 32'(rd_cnt[i]), 32'(n + 1));
            for (int k = 0; k < n; k++) begin
                w = '0;
                for (int b = 0; b < W_A[i]; b++) w = {w[30:0], rxb[8 + k * W_A[i] + b]};
                check($sformatf("%s.miso%0d", tag, k), w, bank(i, 32'(ea[k])));
            end
        end
        check({tag, ".busy"}, 32'(busy[i]), 32'd0);
        check({tag, ".addr"}, addr_of(i), 32'(efin));
    endtask

    task automatic check_reset(string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s%0d.addr", tag, i), addr_of(i), 32'd0);
            check($sformatf("%s%0d.data_o", tag, i), rdo_of(i), 32'd0);
            check($sformatf("%s%0d.wr", tag, i), 32'(wr[i]), 32'd0);
            check($sformatf("%s%0d.rd", tag, i), 32'(rd[i]), 32'd0);
            check($sformatf("%s%0d.busy", tag, i), 32'(busy[i]), 32'd0);
            check($sformatf("%s%0d.miso", tag, i), 32'(miso[i]), 32'd0);
        end
    endtask

    typedef struct {
        int              inst;
        logic [7:0]      cmd;
        int              n;
        logic [3:0][31:0] d;
        logic [3:0][6:0] ea;
        logic [6:0]      efin;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [3:0][31:0] d;
        logic [3:0][6:0]  ea;
        int               i, n, am, a0;
        logic [7:0]       cmd;

        // d and ea are written {k=3, k=2, k=1, k=0}.
        tbl[0] = '{0, 8'h85, 1, {32'h0, 32'h0, 32'h0, 32'h3C}, {7'h0, 7'h0, 7'h0, 7'h05}, 7'h06};
        tbl[1] = '{1, 8'h02, 2, '0, {7'h0, 7'h0, 7'h03, 7'h02}, 7'h04};
        tbl[2] = '{0, 8'hFF, 3, {32'h0, 32'h33, 32'h22, 32'h11}, {7'h0, 7'h01, 7'h00, 7'h7F}, 7'h02};
        tbl[3] = '{2, 8'h84, 3, {32'h0, 32'h0BADBEEF, 32'h12345678, 32'hCAFEF00D},
                   {7'h0, 7'h04, 7'h04, 7'h04}, 7'h04};
        tbl[4] = '{2, 8'h6A, 2, '0, {7'h0, 7'h0, 7'h0A, 7'h0A}, 7'h0A};
        tbl[5] = '{0, 8'h7E, 3, '0, {7'h0, 7'h00, 7'h7F, 7'h7E}, 7'h01};
        tbl[6] = '{1, 8'h90, 2, {32'h0, 32'h0, 32'h1234, 32'hBEEF}, {7'h0, 7'h0, 7'h11, 7'h10}, 7'h12};
        tbl[7] = '{0, 8'hA0, 0, '0, '0, 7'h20};
        tbl[8] = '{1, 8'h33, 0, '0, '0, 7'h33};

        for (int k = 0; k < NI; k++) status[k] = 8'h00;
        wait_clk(5);
        check_reset("rst_init");
        rstb = 1'b1;
        wait_clk(10);

        for (int t = 0; t < 9; t++)
            do_frame($sformatf("tbl%0d", t), tbl[t].inst, tbl[t].cmd, tbl[t].n,
                     tbl[t].d, tbl[t].ea, tbl[t].efin);

        // Word cut after 5 bits: no strobe, address keeps the command value.
        drive_frame(0, 8'h83, 1, {32'h0, 32'h0, 32'h0, 32'hFF}, 13);
        check("partial.wr_cnt", 32'(wlog.size()), 32'd0);
        check("partial.busy", 32'(busy[0]), 32'd0);
        check("partial.addr", addr_of(0), 32'h03);
        do_frame("after_partial", 0, 8'h8A, 1, {32'h0, 32'h0, 32'h0, 32'h5A},
                 {7'h0, 7'h0, 7'h0, 7'h0A}, 7'h0B);

        // Clock enable dropped mid-frame while the SPI bus is quiet.
        pause_at = 12;
        do_frame("ena_pause", 0, 8'h91, 1, {32'h0, 32'h0, 32'h0, 32'hA7},
                 {7'h0, 7'h0, 7'h0, 7'h11}, 7'h12);
        pause_at = -1;

        // Reset in the middle of a frame on the mode-3 instance.
        status[1] = 8'hC3;
        csn[1] = 1'b0;
        wait_clk(H);
        for (int b = 0; b < 10; b++) bit_xfer(1, 1'(b % 3 == 0));
        rstb = 1'b0;
        wait_clk(3);
        check_reset("rst_mid");
        csn[1] = 1'b1;
        wait_clk(3);
        rstb = 1'b1;
        wait_clk(10);
        do_frame("after_rst", 1, 8'h05, 1, '0, {7'h0, 7'h0, 7'h0, 7'h05}, 7'h06);

        // Random frames against the arithmetic address model.
        for (int r = 0; r < 40; r++) begin
            i   = int'($urandom_range(0, NI - 1));
            n   = int'($urandom_range(0, 3));
            cmd = 8'($urandom);
            am  = (1 << AW_A[i]) - 1;
            a0  = int'(cmd) & am;
            for (int k = 0; k < 4; k++) begin
                d[k]  = $urandom;
                ea[k] = 7'((a0 + k * INC_A[i]) & am);
            end
            do_frame($sformatf("rnd%0d", r), i, cmd, n, d, ea, 7'((a0 + n * INC_A[i]) & am));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
